// File: rtl/xbar_wt_loader.sv
// Crossbar weight loader: assembles one matrix row per valid/ready beat in a
// shadow buffer, then issues a single-cycle prog_wt with the complete matrix.
module xbar_wt_loader #(
  parameter int XBAR_SIZE = 4,
  parameter int WT_BITS   = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   load_start,
  input  logic                                   abort,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [XBAR_SIZE*WT_BITS-1:0]           in_row,
  input  logic                                   in_last,
  output logic                                   prog_wt,
  output logic [XBAR_SIZE*XBAR_SIZE*WT_BITS-1:0] wr_weight,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  localparam int ROW_W = XBAR_SIZE * WT_BITS;
  localparam int MAT_W = XBAR_SIZE * ROW_W;
  localparam int CNT_W = (XBAR_SIZE > 1) ? $clog2(XBAR_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(XBAR_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PROG,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic             err_q, err_d;
  logic [MAT_W-1:0] buf_q;
  logic             accept;

  assign in_ready  = (state_q == LOAD) && !abort;
  assign accept    = in_valid && in_ready;
  assign prog_wt   = (state_q == PROG);
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign wr_weight = buf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      err_q     <= err_d;
    end
  end

  // Rows land in place as they arrive; a framing error leaves them written but unprogrammed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q <= '0;
    end else begin
      for (int r = 0; r < XBAR_SIZE; r++) begin
        if (accept && (row_cnt_q == CNT_W'(r))) begin
          buf_q[r*ROW_W +: ROW_W] <= in_row;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d   = LOAD;
          row_cnt_d = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d   = IDLE;
          row_cnt_d = '0;
        end else if (in_valid) begin
          if ((row_cnt_q == LAST_ROW) && in_last) begin
            state_d = PROG;
          end else if (in_last || (row_cnt_q == LAST_ROW)) begin
            state_d   = IDLE;
            row_cnt_d = '0;
            err_d     = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      PROG:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_xbar_wt_loader.sv
// Self-checking bench for xbar_wt_loader: directed scenarios plus random traffic,
// compared every cycle against a matrix-level behavioural model.
module tb_xbar_wt_loader;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int ROW_W = N * W;
  localparam int MAT_W = N * ROW_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             load_start = 1'b0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ROW_W-1:0] in_row = '0;
  logic             in_last = 1'b0;
  logic             prog_wt;
  logic [MAT_W-1:0] wr_weight;
  logic             busy;
  logic             done;
  logic             err;

  int n_cmp = 0;
  int n_bad = 0;
  int prog_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  // Model state: 0 idle, 1 loading, 2 programming, 3 done
  int         m_phase = 0;
  int         m_rows = 0;
  logic       m_err = 1'b0;
  logic [W-1:0] m_w [N][N];
  logic [ROW_W-1:0] mem_row [N];

  xbar_wt_loader #(.XBAR_SIZE(N), .WT_BITS(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .in_last    (in_last),
    .prog_wt    (prog_wt),
    .wr_weight  (wr_weight),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [MAT_W-1:0] act,
                              input logic [MAT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] model_matrix();
    logic [MAT_W-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++)
        v[(r*N+k)*W +: W] = m_w[r][k];
    return v;
  endfunction

  // Behavioural model advanced on each clock edge from the sampled inputs
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0;
      m_rows  = 0;
      m_err   = 1'b0;
      for (int r = 0; r < N; r++)
        for (int k = 0; k < N; k++)
          m_w[r][k] = '0;
    end else begin
      m_err = 1'b0;
      case (m_phase)
        0: if (load_start) begin m_phase = 1; m_rows = 0; end
        1: begin
          if (abort) begin
            m_phase = 0;
            m_rows  = 0;
          end else if (in_valid) begin
            for (int k = 0; k < N; k++) m_w[m_rows][k] = in_row[k*W +: W];
            if (in_last && m_rows == N-1) m_phase = 2;
            else if (in_last || m_rows == N-1) begin
              m_phase = 0;
              m_rows  = 0;
              m_err   = 1'b1;
            end else m_rows++;
          end
        end
        2: m_phase = 3;
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison plus a simple weight memory that captures on prog_wt
  always @(negedge clk) begin
    check_output("in_ready", MAT_W'(in_ready), MAT_W'(m_phase == 1 && !abort));
    check_output("prog_wt", MAT_W'(prog_wt), MAT_W'(m_phase == 2));
    check_output("done", MAT_W'(done), MAT_W'(m_phase == 3));
    check_output("busy", MAT_W'(busy), MAT_W'(m_phase != 0));
    check_output("err", MAT_W'(err), MAT_W'(m_err));
    check_output("wr_weight", wr_weight, model_matrix());
    if (prog_wt) begin
      prog_cnt++;
      for (int r = 0; r < N; r++) mem_row[r] = wr_weight[r*ROW_W +: ROW_W];
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic apply_stimulus(input logic ls, input logic ab, input logic v,
                                input logic lst, input logic [ROW_W-1:0] row);
    load_start = ls;
    abort      = ab;
    in_valid   = v;
    in_last    = lst;
    in_row     = row;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, '0);
  endtask

  logic [ROW_W-1:0] rows [N];
  logic [MAT_W-1:0] full_mat;

  task automatic full_load();
    apply_stimulus(1, 0, 0, 0, '0);
    for (int r = 0; r < N; r++) apply_stimulus(0, 0, 1, (r == N-1), rows[r]);
    check_output("prog_after_last", MAT_W'(prog_wt), MAT_W'(1));
    check_output("prog_matrix", wr_weight, full_mat);
    idle_cycles(1);
    check_output("done_next", MAT_W'(done), MAT_W'(1));
    idle_cycles(2);
  endtask

  initial begin
    rows[0] = 32'h04030201;
    rows[1] = 32'h08070605;
    rows[2] = 32'h0C0B0A09;
    rows[3] = 32'h100F0E0D;
    full_mat = 128'h100F0E0D_0C0B0A09_08070605_04030201;
    for (int r = 0; r < N; r++) mem_row[r] = '0;

    #3;
    check_output("reset_busy", MAT_W'(busy), '0);
    check_output("reset_in_ready", MAT_W'(in_ready), '0);
    check_output("reset_wr_weight", wr_weight, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle_cycles(1);

    $display("[TB] scenario 1: full load");
    full_load();
    check_output("s1_prog_cnt", MAT_W'(prog_cnt), MAT_W'(1));
    check_output("s1_done_cnt", MAT_W'(done_cnt), MAT_W'(1));
    check_output("s1_mem_row2", MAT_W'(mem_row[2]), MAT_W'(32'h0C0B0A09));
    check_output("s1_model_pin", model_matrix(), full_mat);
    check_output("s1_busy", MAT_W'(busy), '0);

    $display("[TB] scenario 2: gaps and idle traffic");
    apply_stimulus(0, 0, 1, 0, 32'hFFFFFFFF);
    apply_stimulus(0, 0, 1, 1, 32'hEEEEEEEE);
    apply_stimulus(1, 0, 0, 0, '0);
    for (int r = 0; r < N; r++) begin
      apply_stimulus(0, 0, 1, (r == N-1), rows[r]);
      if (r != N-1) begin
        apply_stimulus(0, 0, 0, 0, $urandom);
        apply_stimulus(0, 0, 0, 1, $urandom);
      end
    end
    check_output("s2_prog_matrix", wr_weight, full_mat);
    idle_cycles(3);
    check_output("s2_prog_cnt", MAT_W'(prog_cnt), MAT_W'(2));
    check_output("s2_mem_row0", MAT_W'(mem_row[0]), MAT_W'(32'h04030201));
    check_output("s2_mem_row3", MAT_W'(mem_row[3]), MAT_W'(32'h100F0E0D));

    $display("[TB] scenario 3: early in_last");
    apply_stimulus(1, 0, 0, 0, '0);
    apply_stimulus(0, 0, 1, 0, 32'hDEADBEEF);
    apply_stimulus(0, 0, 1, 1, 32'h11223344);
    check_output("s3_err", MAT_W'(err), MAT_W'(1));
    idle_cycles(2);
    check_output("s3_err_cnt", MAT_W'(err_cnt), MAT_W'(1));
    check_output("s3_prog_cnt", MAT_W'(prog_cnt), MAT_W'(2));
    check_output("s3_mem_row0", MAT_W'(mem_row[0]), MAT_W'(32'h04030201));
    check_output("s3_busy", MAT_W'(busy), '0);

    $display("[TB] scenario 4: missing in_last");
    apply_stimulus(1, 0, 0, 0, '0);
    for (int r = 0; r < N; r++) apply_stimulus(0, 0, 1, 0, $urandom);
    apply_stimulus(0, 0, 1, 0, 32'h55555555);
    idle_cycles(2);
    check_output("s4_err_cnt", MAT_W'(err_cnt), MAT_W'(2));
    check_output("s4_prog_cnt", MAT_W'(prog_cnt), MAT_W'(2));

    $display("[TB] scenario 5: abort and ignored start");
    apply_stimulus(1, 0, 0, 0, '0);
    apply_stimulus(0, 0, 1, 0, 32'hA1A2A3A4);
    apply_stimulus(0, 0, 1, 0, 32'hB1B2B3B4);
    apply_stimulus(1, 0, 0, 0, '0);
    apply_stimulus(0, 0, 1, 0, 32'hC1C2C3C4);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_row   = 32'hD1D2D3D4;
    #1;
    check_output("s5_ready_abort", MAT_W'(in_ready), '0);
    @(posedge clk);
    #1;
    idle_cycles(1);
    check_output("s5_busy", MAT_W'(busy), '0);
    idle_cycles(2);
    check_output("s5_err_cnt", MAT_W'(err_cnt), MAT_W'(2));
    check_output("s5_prog_cnt", MAT_W'(prog_cnt), MAT_W'(2));

    $display("[TB] scenario 6: async reset mid-load");
    apply_stimulus(1, 0, 0, 0, '0);
    for (int r = 0; r < 3; r++) apply_stimulus(0, 0, 1, 0, $urandom | 32'h1);
    in_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    check_output("s6_busy", MAT_W'(busy), '0);
    check_output("s6_in_ready", MAT_W'(in_ready), '0);
    check_output("s6_wr_weight", wr_weight, '0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    idle_cycles(1);
    check_output("s6_prog_cnt_rst", MAT_W'(prog_cnt), MAT_W'(2));
    full_load();
    check_output("s6_prog_cnt", MAT_W'(prog_cnt), MAT_W'(3));
    check_output("s6_done_cnt", MAT_W'(done_cnt), MAT_W'(3));
    check_output("s6_mem_row2", MAT_W'(mem_row[2]), MAT_W'(32'h0C0B0A09));

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom_range(3) == 0), ($urandom_range(15) == 0),
                     ($urandom_range(3) != 0),
                     ((m_rows == N-1) ^ ($urandom_range(9) == 0)), $urandom);
    end
    apply_stimulus(0, 1, 0, 0, '0);
    idle_cycles(4);
    check_output("rand_idle", MAT_W'(busy), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
